// File: rtl/note_sequencer_pkg.sv
// Shared constants for the note sequencer: ASCII commands,
// note codes and the playback FSM encoding.
package note_sequencer_pkg;

  localparam logic [7:0] ASC_REST     = 8'h30;
  localparam logic [7:0] ASC_NOTE_LO  = 8'h31;
  localparam logic [7:0] ASC_NOTE_HI  = 8'h37;
  localparam logic [7:0] ASC_FLUSH_UC = 8'h58;
  localparam logic [7:0] ASC_FLUSH_LC = 8'h78;

  localparam logic [2:0] NOTE_REST = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  function automatic logic is_note(input logic [7:0] b);
    return (b == ASC_REST) ||
           ((b >= ASC_NOTE_LO) && (b <= ASC_NOTE_HI));
  endfunction

  function automatic logic is_flush(input logic [7:0] b);
    return (b == ASC_FLUSH_UC) || (b == ASC_FLUSH_LC);
  endfunction

endpackage

// File: rtl/note_sequencer_fifo.sv
// Synchronous note-code FIFO with flush; pop reads the
// head combinationally, a push into a full FIFO needs a pop.
module note_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic [4:0] count,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 5'(DEPTH));
  assign empty   = (count == 5'd0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Serial-byte driven note player: decodes ASCII note digits,
// queues them and plays each for a fixed time plus a gap.
import note_sequencer_pkg::*;

module note_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int NOTE_TICKS = 25000000,
  parameter int GAP_TICKS  = 2500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [2:0] nota,
  output logic       note_pulse,
  output logic       busy,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int MAX_T =
    (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [TW-1:0] NOTE_LD = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] ONE     = TW'(1);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    code, code_n;
  logic [2:0]    nota_n;
  logic          pulse_n;
  logic          push, pop, flush;
  logic [2:0]    head;
  logic          full, empty;

  assign push  = rx_valid && is_note(rx_data);
  assign flush = rx_valid && is_flush(rx_data);
  assign busy  = (state != ST_IDLE);

  note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rx_data[2:0]),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    timer_n = timer;
    code_n  = code;
    nota_n  = nota;
    pulse_n = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      state_n = ST_IDLE;
      timer_n = '0;
      nota_n  = NOTE_REST;
    end else begin
      unique case (state)
        ST_IDLE: begin
          nota_n = NOTE_REST;
          if (!empty) begin
            pop     = 1'b1;
            code_n  = head;
            state_n = ST_LOAD;
          end
        end
        ST_LOAD: begin
          nota_n  = code;
          timer_n = NOTE_LD;
          pulse_n = (code != NOTE_REST);
          state_n = ST_PLAY;
        end
        ST_PLAY: begin
          if (timer == '0) begin
            nota_n  = NOTE_REST;
            timer_n = GAP_LD;
            state_n = ST_GAP;
          end else begin
            timer_n = timer - ONE;
          end
        end
        ST_GAP: begin
          // Pop one tick early so the LOAD cycle is the gap's last tick.
          if (!empty && (timer == '0 || timer == ONE)) begin
            pop     = 1'b1;
            code_n  = head;
            state_n = ST_LOAD;
          end else if (timer == '0) begin
            state_n = ST_IDLE;
          end else begin
            timer_n = timer - ONE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ST_IDLE;
      timer      <= '0;
      code       <= NOTE_REST;
      nota       <= NOTE_REST;
      note_pulse <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      code       <= code_n;
      nota       <= nota_n;
      note_pulse <= pulse_n;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
